// File: rtl/rr_mux.sv
`default_nettype none
// ============================================================================
//  Module      : rr_mux
//  Description : Registered NUM_CH-to-1 multiplexer of WIDTH-bit channels with
//                valid/ready handshakes. The source channel is either a fixed
//                select or round-robin among the requesting channels. A single
//                output register gives one-cycle latency at full throughput.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_mux #(
    parameter  int NUM_CH = 4,
    parameter  int WIDTH  = 16,
    localparam int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        select,
    input  logic [NUM_CH*WIDTH-1:0] inData,
    input  logic [NUM_CH-1:0]       inValid,
    output logic [NUM_CH-1:0]       inReady,
    output logic [WIDTH-1:0]        outData,
    output logic                    outValid,
    output logic [SEL_W-1:0]        outSel,
    input  logic                    outReady
);

    // Channel count and last index at select width (one extra bit so the
    // count itself is representable for range checks).
    localparam logic [SEL_W:0]   c_num_ch = (SEL_W+1)'(NUM_CH);
    localparam logic [SEL_W-1:0] c_last   = SEL_W'(NUM_CH - 1);

    logic [WIDTH-1:0] w_ch [NUM_CH];
    logic             w_load;
    logic             w_grant;
    logic [SEL_W-1:0] w_grant_idx;
    logic [SEL_W:0]   w_cand;

    logic [SEL_W-1:0] r_ptr;
    logic [WIDTH-1:0] r_out_data;
    logic [SEL_W-1:0] r_out_sel;
    logic             r_out_valid;

    // Split the flat input bus into one word per channel.
    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            assign w_ch[gi] = inData[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // The output register may take a new word when empty or being drained.
    assign w_load = !r_out_valid || outReady;

    // Grant selection: fixed channel, or first valid channel at/after r_ptr.
    always_comb begin
        w_grant     = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        if (mode) begin
            for (int k = 0; k < NUM_CH; k++) begin
                w_cand = {1'b0, r_ptr} + (SEL_W+1)'(k);
                if (w_cand >= c_num_ch) begin
                    w_cand = w_cand - c_num_ch;
                end
                if (!w_grant && inValid[w_cand[SEL_W-1:0]]) begin
                    w_grant     = 1'b1;
                    w_grant_idx = w_cand[SEL_W-1:0];
                end
            end
        end else if ({1'b0, select} < c_num_ch) begin
            if (inValid[select]) begin
                w_grant     = 1'b1;
                w_grant_idx = select;
            end
        end
    end

    // Ready goes only to the granted channel, and never while in reset.
    always_comb begin
        inReady = '0;
        if (rst_n && w_load && w_grant) begin
            inReady[w_grant_idx] = 1'b1;
        end
    end

    // Output register and round-robin pointer; a held word is dropped on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr       <= '0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            if (w_grant) begin
                r_out_data  <= w_ch[w_grant_idx];
                r_out_sel   <= w_grant_idx;
                r_out_valid <= 1'b1;
                if (mode) begin
                    if (w_grant_idx == c_last) begin
                        r_ptr <= '0;
                    end else begin
                        r_ptr <= w_grant_idx + 1'b1;
                    end
                end
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign outData  = r_out_data;
    assign outSel   = r_out_sel;
    assign outValid = r_out_valid;

endmodule
`default_nettype wire

// File: doc/rr_mux.md
# rr_mux

Parametrised, registered N-channel W-bit multiplexer with valid/ready handshakes. It generalises the 2:1 single-bit mux in two ways: it routes any of `NUM_CH` channels of `WIDTH` bits, and it selects either a fixed channel or round-robin among the requesting channels. One output register gives one-cycle latency and full throughput. It sits between multiple producers (register-file read ports, memory/IO sources) and one consumer that can stall.

## Interface
- `NUM_CH`, 4: number of input channels, ≥2.
- `WIDTH`, 16: data width per channel, ≥1.
- `SEL_W`: derived localparam, `max(1, clog2(NUM_CH))`; not overridable.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `mode`  in  1  0 = fixed select, 1 = round-robin.
- `select`  in  SEL_W  channel used in fixed mode; ignored in round-robin mode.
- `inData`  in  NUM_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- `inValid`  in  NUM_CH  per-channel valid.
- `inReady`  out  NUM_CH  per-channel ready; combinational, one-hot or zero.
- `outData`  out  WIDTH  registered data.
- `outValid`  out  1  registered valid.
- `outSel`  out  SEL_W  channel index that produced `outData`.
- `outReady`  in  1  consumer ready.

## Operation
- `load = !outValid || outReady`. The output register accepts new data only when `load` is 1.
- Grant selection is combinational:
  - Fixed mode: the grant is `select` if `select < NUM_CH` and `inValid[select]`. Otherwise there is no grant. An out-of-range `select` never grants.
  - Round-robin mode: the grant is the first i with `inValid[i]`, searching `ptr, ptr+1, …` modulo `NUM_CH`. If no channel is valid, there is no grant.
- `inReady[g] = load && grant && (g == grantIdx)`. All other `inReady` bits are 0. A transfer on channel i occurs when `inValid[i] && inReady[i]`.
- When `load` is 1 and there is a grant:
  - `outData <= inData[grantIdx]`, `outSel <= grantIdx`, `outValid <= 1`.
  - In round-robin mode, `ptr <= (grantIdx+1) mod NUM_CH`. The wrap from `NUM_CH-1` goes to 0.
  - In fixed mode, `ptr` is unchanged.
- When `load` is 1 and there is no grant: `outValid <= 0`. `outData` and `outSel` hold their previous values.
- When `load` is 0 (`outValid && !outReady`): all registers hold, and every `inReady` bit is 0.
- Changes to `mode` or `select` take effect on the next grant evaluation. They never disturb a word already held in the output register.
- A producer may drop `inValid` without a handshake. The block never captures data when `inReady` was 0.

## Timing
- Reset (`rst_n` low, asynchronous): `outValid=0`, `outData=0`, `outSel=0`, `ptr=0`. `inReady` is forced to 0 for as long as `rst_n` is low.
  - A word held at reset assertion is discarded.
  - The first grant after reset release is possible at the first rising edge with `rst_n` high.
- Latency: a transfer at edge N appears on `outData`/`outValid` after edge N.
- Throughput: one word per cycle while `outReady=1` and at least one eligible channel is valid.
- Simultaneous consume and load: with `outValid=1`, `outReady=1` and a grant, the held word is consumed and the new word loads on the same edge. There is no bubble.
- Stall: `outData`, `outSel` and `outValid` stay stable for as long as `outValid=1` and `outReady=0`.
- Fairness: with all channels continuously valid in round-robin mode, each channel is granted exactly once in every `NUM_CH` consecutive grants.

## Test plan
- Reset: drive `rst_n=0` mid-stream with `outValid=1` → immediately `outValid=0`, `outData=0`, `outSel=0` and `inReady=0`. After release, round-robin restarts at channel 0.
- Exhaustive 2:1 equivalence:
  - Configuration: `NUM_CH=2`, `WIDTH=1`, fixed mode, `outReady=1`, both valid.
  - Stimulus: all 8 combinations of `select`/`inData`.
  - Required: `outData` one cycle later equals `select ? inData[1] : inData[0]`, and `inReady` is one-hot at `select`.
- Fixed mode:
  - Configuration: `NUM_CH=4`, `WIDTH=8`, data 0x10/0x11/0x12/0x13, all valid, `select=2`.
  - Required: only `inReady[2]=1`; next cycle `outData=0x12`, `outSel=2`.
  - Then clear `inValid[2]` → `outValid=0` on the next cycle.
- Round-robin fairness: all 4 channels valid, `outReady=1` for 9 cycles → `outSel` sequence 0,1,2,3,0,1,2,3,0 with `outValid=1` every cycle.
- Sparse round-robin: only channels 1 and 3 valid → `outSel` alternates 1,3,1,3. Then only channel 3 valid → 3 every cycle, and `ptr` wraps to 0.
- Backpressure: round-robin, all valid, hold `outReady=0` for 3 cycles after the first word.
  - During the stall: `outData` and `outSel` are stable and `inReady=0`.
  - On release: the held word is consumed and the next channel loads on the same edge.
